// File: rtl/gradient_batch_accumulator.sv
// gradient_batch_accumulator
//
// Averages N_CH independent signed gradient streams over batches of
// B = 2^BATCH_LOG2 samples. One sample is taken every COUNT_DELAY+1 enabled
// clock cycles. When the B-th sample of a batch is taken, the batch average
// is registered on grad_out and out_valid is raised. The block then holds
// that result until the consumer accepts it with out_ready.
//
// Optional feature (macro GRAD_SAT_EN):
//   defined   - an averaged result outside the DATA_W signed range saturates
//   undefined - an averaged result keeps only its low DATA_W bits (wraps)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-low reset (priority over everything)
//   enable      advances the sample-period counter and permits sampling
//   clear       synchronous discard of the partial batch and pending result
//   grad_in     N_CH packed signed gradients, channel k at [k*DATA_W +: DATA_W]
//   grad_out    N_CH packed batch averages, same packing as grad_in
//   out_valid   grad_out holds a completed batch
//   out_ready   consumer accepts grad_out
//   sample_cnt  samples accumulated in the current batch
module gradient_batch_accumulator #(
    parameter int N_CH        = 8,
    parameter int DATA_W      = 16,
    parameter int BATCH_LOG2  = 2,
    parameter int ACC_W       = 32,
    parameter int COUNT_DELAY = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [N_CH*DATA_W-1:0] grad_in,
    output logic [N_CH*DATA_W-1:0] grad_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BATCH_LOG2:0]    sample_cnt
);

    localparam int CNT_W = (COUNT_DELAY > 0) ? $clog2(COUNT_DELAY + 1) : 1;
    localparam int B     = 1 << BATCH_LOG2;
    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(COUNT_DELAY);
    localparam logic [BATCH_LOG2:0]   SAMPLE_LAST = (BATCH_LOG2 + 1)'(B - 1);

    // The accumulator must hold a full batch sum without overflow.
    generate
        if (ACC_W < DATA_W + BATCH_LOG2) begin : g_bad_acc_w
            $error("ACC_W must be >= DATA_W + BATCH_LOG2");
        end
        if (BATCH_LOG2 < 0 || BATCH_LOG2 > 10) begin : g_bad_batch
            $error("BATCH_LOG2 must be in 0..10");
        end
    endgenerate

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [BATCH_LOG2:0]      r_sample_cnt;
    logic                     r_out_valid;
    logic [N_CH*DATA_W-1:0]   r_grad_out;
    logic signed [ACC_W-1:0]  r_acc [N_CH];

    logic                     w_strobe;
    logic                     w_last;
    logic                     w_accept;
    logic signed [ACC_W-1:0]  w_sum [N_CH];
    logic [DATA_W-1:0]        w_res [N_CH];

    // Reduce a shifted batch sum to DATA_W bits.
    function automatic logic [DATA_W-1:0] f_fit(input logic signed [ACC_W-1:0] v);
`ifdef GRAD_SAT_EN
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > max_v)
            f_fit = DATA_W'(max_v);
        else if (v < min_v)
            f_fit = DATA_W'(min_v);
        else
            f_fit = DATA_W'(v);
`else
        f_fit = DATA_W'(v);
`endif
    endfunction

    // Running sum including the current input; on the last sample of a
    // batch this is the full batch sum, so the arithmetic shift gives the
    // floored average directly.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_sum[k] = r_acc[k] + ACC_W'($signed(grad_in[k*DATA_W +: DATA_W]));
            w_res[k] = f_fit(w_sum[k] >>> BATCH_LOG2);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        w_last      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_RUN: begin
                w_strobe = enable && (r_cnt == CNT_LAST);
                w_last   = w_strobe && (r_sample_cnt == SAMPLE_LAST);
                if (w_last)
                    w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_accept = r_out_valid && out_ready;
                if (w_accept)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
        // clear wins over a simultaneous strobe or handshake
        if (clear)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_sample_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_grad_out   <= '0;
            for (int k = 0; k < N_CH; k++)
                r_acc[k] <= '0;
        end else if (clear) begin
            // grad_out keeps its old value; only out_valid is withdrawn
            r_cnt        <= '0;
            r_sample_cnt <= '0;
            r_out_valid  <= 1'b0;
            for (int k = 0; k < N_CH; k++)
                r_acc[k] <= '0;
        end else begin
            // Counter parks at 0 while a result is pending, so a new period
            // starts cleanly after the handshake.
            if (r_state == S_HOLD)
                r_cnt <= '0;
            else if (enable)
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

            if (w_last) begin
                for (int k = 0; k < N_CH; k++) begin
                    r_grad_out[k*DATA_W +: DATA_W] <= w_res[k];
                    r_acc[k] <= '0;
                end
                r_sample_cnt <= '0;
                r_out_valid  <= 1'b1;
            end else if (w_strobe) begin
                for (int k = 0; k < N_CH; k++)
                    r_acc[k] <= w_sum[k];
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end

            if (w_accept)
                r_out_valid <= 1'b0;
        end
    end

    assign grad_out   = r_grad_out;
    assign out_valid  = r_out_valid;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_gradient_batch_accumulator.sv
// Testbench for gradient_batch_accumulator: 2 channels, 16-bit data,
// batch of 4, sample period of 4 cycles. Table of directed batches with
// hand-computed averages, plus sequences for stall, clear, enable freeze
// and reset while a result is held.
module tb_gradient_batch_accumulator;

    localparam int N_CH = 2;
    localparam int DW   = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 clear;
    logic                 out_ready;
    logic [N_CH*DW-1:0]   grad_in;
    logic [N_CH*DW-1:0]   grad_out;
    logic                 out_valid;
    logic [2:0]           sample_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gradient_batch_accumulator #(
        .N_CH(N_CH), .DATA_W(DW), .BATCH_LOG2(2), .ACC_W(32), .COUNT_DELAY(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .grad_in(grad_in), .grad_out(grad_out), .out_valid(out_valid),
        .out_ready(out_ready), .sample_cnt(sample_cnt)
    );

    typedef struct {
        logic [3:0][15:0] s0;   // ch0 samples, element 0 first
        logic [3:0][15:0] s1;   // ch1 samples
        int               e0;   // expected ch0 average
        int               e1;   // expected ch1 average
    } vec_t;

    vec_t vecs[6];

    function automatic logic [3:0][15:0] mk(input int a, input int b, input int c, input int d);
        mk = {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sample period starting with the counter at 0: grad_in is held for
    // the whole period and captured on its 4th edge.
    task automatic window(input logic [15:0] a, input logic [15:0] b, input int exp_cnt, input string name);
        grad_in = {b, a};
        tick(3);
        chk({name, " valid_mid"}, 32'(out_valid), 0);
        tick(1);
        chk({name, " sample_cnt"}, 32'(sample_cnt), exp_cnt);
    endtask

    task automatic run_batch(input logic [3:0][15:0] s0, input logic [3:0][15:0] s1,
                             input int e0, input int e1, input string name);
        for (int i = 0; i < 3; i++)
            window(s0[i], s1[i], i + 1, name);
        window(s0[3], s1[3], 0, name);
        chk({name, " valid"}, 32'(out_valid), 1);
        chk({name, " ch0"}, $signed(grad_out[15:0]), e0);
        chk({name, " ch1"}, $signed(grad_out[31:16]), e1);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk({name, " valid_after_hs"}, 32'(out_valid), 0);
    endtask

    initial begin
        vecs[0] = '{mk(8, 8, 8, 8),             mk(-8, -8, -8, -8),             8,     -8};
        vecs[1] = '{mk(1, 2, 3, 3),             mk(-1, -2, -3, -3),             2,     -3};
        vecs[2] = '{mk(32767, 1, 0, 0),         mk(-32768, -32768, -32768, -32768), 8192, -32768};
        vecs[3] = '{mk(32767, 32767, 32767, 32767), mk(-1, 0, 0, 0),            32767, -1};
        vecs[4] = '{mk(5, -5, 7, -7),           mk(3, 0, 0, 0),                 0,     0};
        vecs[5] = '{mk(100, 200, 300, 400),     mk(-3, -3, -3, -2),             250,   -3};

        reset = 1'b0; enable = 1'b1; clear = 1'b0; out_ready = 1'b0; grad_in = '0;
        tick(3);
        chk("reset valid", 32'(out_valid), 0);
        chk("reset grad_out", $signed(grad_out), 0);
        chk("reset sample_cnt", 32'(sample_cnt), 0);
        reset = 1'b1;

        // Table: first entry doubles as the 16-cycle first-result latency check.
        for (int i = 0; i < 6; i++) begin
            out_ready = (i == 4);   // ready with nothing pending must be ignored
            run_batch(vecs[i].s0, vecs[i].s1, vecs[i].e0, vecs[i].e1, $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // Long stall in HOLD with changing inputs and enable.
        run_batch(vecs[1].s0, vecs[1].s1, 2, -3, "stall");
        for (int i = 0; i < 50; i++) begin
            grad_in = $urandom;
            enable  = i[0];
            tick(1);
        end
        chk("stall valid", 32'(out_valid), 1);
        chk("stall ch0", $signed(grad_out[15:0]), 2);
        chk("stall ch1", $signed(grad_out[31:16]), -3);
        chk("stall sample_cnt", 32'(sample_cnt), 0);
        enable = 1'b1;
        handshake("stall");
        run_batch(vecs[0].s0, vecs[0].s1, 8, -8, "post_stall");
        handshake("post_stall");

        // clear on the strobe edge of the 4th sample.
        window(16'd1000, -16'sd1000, 1, "clr");
        window(16'd1000, -16'sd1000, 2, "clr");
        window(16'd1000, -16'sd1000, 3, "clr");
        tick(3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr valid", 32'(out_valid), 0);
        chk("clr sample_cnt", 32'(sample_cnt), 0);
        run_batch(mk(4, 4, 4, 8), mk(-4, -4, -4, -8), 5, -5, "post_clr");

        // clear together with a handshake in HOLD.
        clear = 1'b1; out_ready = 1'b1;
        tick(1);
        clear = 1'b0; out_ready = 1'b0;
        chk("clr_hs valid", 32'(out_valid), 0);
        chk("clr_hs sample_cnt", 32'(sample_cnt), 0);

        // enable low for 5 cycles mid-period stretches the period by 5.
        grad_in = {16'd20, 16'd10};
        tick(2);
        enable = 1'b0;
        tick(5);
        chk("freeze sample_cnt", 32'(sample_cnt), 0);
        enable = 1'b1;
        tick(1);
        chk("freeze pre_strobe", 32'(sample_cnt), 0);
        tick(1);
        chk("freeze strobe", 32'(sample_cnt), 1);
        window(16'd10, 16'd20, 2, "freeze");
        window(16'd10, 16'd20, 3, "freeze");
        window(16'd10, 16'd20, 0, "freeze");
        chk("freeze valid", 32'(out_valid), 1);
        chk("freeze ch0", $signed(grad_out[15:0]), 10);
        chk("freeze ch1", $signed(grad_out[31:16]), 20);

        // reset while holding a result.
        reset = 1'b0;
        tick(1);
        chk("hold_rst valid", 32'(out_valid), 0);
        chk("hold_rst grad_out", $signed(grad_out), 0);
        chk("hold_rst sample_cnt", 32'(sample_cnt), 0);
        reset = 1'b1;
        run_batch(vecs[5].s0, vecs[5].s1, 250, -3, "post_rst");
        handshake("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
